// File: rtl/radix2_nonrestoring_divider.sv
// radix2_nonrestoring_divider
//   Sequential radix-2 non-restoring divider. One start pulse in IDLE launches a
//   division that takes N+2 cycles: LOAD, N iteration steps, then FIX. A divisor of 0
//   skips the iterations, so that case takes 2 cycles. Results stay on the outputs
//   until the next accepted operation completes.
//
//   Build option: define SIGNED_DIV_EN for two's-complement operands. The quotient
//   truncates toward zero and the remainder takes the dividend's sign. When the macro
//   is undefined, operands and results are unsigned.
//
//   Parameters:
//     N      operand / result width (even, >= 4)
//     alpha  MSB index of the iteration counter (alpha+1 bits must hold N)
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     start               request, sampled only in IDLE
//     data_inN, data_inD  dividend / divisor, latched on the edge that accepts start
//     quotient, remainder registered results
//     done                one-cycle completion pulse
//     busy                high while an operation is in flight
//     div_zero            registered divide-by-zero flag, updated with done
module radix2_nonrestoring_divider #(
  parameter int unsigned N     = 8,
  parameter int unsigned alpha = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] data_inN,
  input  logic [N-1:0] data_inD,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_zero
);

  localparam int unsigned CntW = alpha + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StIter, StFix} state_e;

  state_e         state;
  logic [N-1:0]   hold_n;
  logic [N-1:0]   hold_d;
  logic [N-1:0]   q_reg;
  logic [N-1:0]   d_reg;
  logic [N:0]     r_reg;     // partial remainder, two's complement
  logic [alpha:0] count;
  logic           neg_q;
  logic           neg_r;
  logic           zero_q;

  logic           sign_n;
  logic           sign_d;
  logic [N-1:0]   mag_n;
  logic [N-1:0]   mag_d;
  logic [N:0]     d_ext;
  logic [N:0]     r_shift;
  logic [N:0]     r_step;
  logic [N-1:0]   q_shift;
  logic [N-1:0]   r_fix;
  logic [N-1:0]   q_final;
  logic [N-1:0]   r_final;

  // Operand signs and magnitudes from the hold registers. In the unsigned build the
  // signs are tied low, so the magnitude and sign-correction paths become pass-through.
  always_comb begin
`ifdef SIGNED_DIV_EN
    sign_n = hold_n[N-1];
    sign_d = hold_d[N-1];
`else
    sign_n = 1'b0;
    sign_d = 1'b0;
`endif
    // -2^(N-1) maps onto itself, which is the correct unsigned magnitude.
    mag_n = sign_n ? -hold_n : hold_n;
    mag_d = sign_d ? -hold_d : hold_d;
  end

  // One non-restoring step. The shifted remainder may leave the N+1 bit range, but the
  // result after adding or subtracting D lies in [-D, D), so the modular wrap is harmless.
  always_comb begin
    d_ext   = {1'b0, d_reg};
    r_shift = {r_reg[N-1:0], q_reg[N-1]};
    r_step  = r_reg[N] ? (r_shift + d_ext) : (r_shift - d_ext);
    q_shift = {q_reg[N-2:0], ~r_step[N]};
    // Final correction: after the fix-up the remainder fits in N bits.
    r_fix   = r_reg[N] ? (r_reg[N-1:0] + d_reg) : r_reg[N-1:0];
    q_final = neg_q ? -q_reg : q_reg;
    r_final = neg_r ? -r_fix : r_fix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      hold_n    <= '0;
      hold_d    <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      count     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      zero_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            hold_n <= data_inN;
            hold_d <= data_inD;
            busy   <= 1'b1;
            state  <= StLoad;
          end
        end
        StLoad: begin
          q_reg  <= mag_n;
          d_reg  <= mag_d;
          r_reg  <= '0;
          count  <= CntW'(N);
          neg_q  <= sign_n ^ sign_d;
          neg_r  <= sign_n;
          zero_q <= (hold_d == '0);
          state  <= (hold_d == '0) ? StFix : StIter;
        end
        StIter: begin
          r_reg <= r_step;
          q_reg <= q_shift;
          count <= count - CntW'(1);
          if (count == CntW'(1)) begin
            state <= StFix;
          end
        end
        StFix: begin
          if (zero_q) begin
            quotient  <= '1;
            remainder <= hold_n;
          end else begin
            quotient  <= q_final;
            remainder <= r_final;
          end
          div_zero <= zero_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_radix2_nonrestoring_divider.sv
module tb_radix2_nonrestoring_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] data_inN;
  logic [N-1:0] data_inD;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         done;
  logic         busy;
  logic         div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  radix2_nonrestoring_divider #(.N(N), .alpha(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_inN  (data_inN),
    .data_inD  (data_inD),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, which truncates toward zero with the
  // remainder taking the dividend's sign.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic [N-1:0] r,
                                output logic z);
    int qi;
    int ri;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef SIGNED_DIV_EN
      qi = int'($signed(a)) / int'($signed(b));
      ri = int'($signed(a)) % int'($signed(b));
`else
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
`endif
      q = qi[N-1:0];
      r = ri[N-1:0];
      z = 1'b0;
    end
  endfunction

  // One division; done must appear N+2 edges after the start edge (2 for a zero divisor).
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         ez;
    int           cyc;
    model(a, b, eq, er, ez);
    @(negedge clk);
    data_inN = a;
    data_inD = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    data_inN = N'($urandom);
    data_inD = N'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), (b == '0) ? 32'd2 : 32'(N + 2));
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_dz"}, 32'(div_zero), 32'(ez));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         ez;
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           ndone;
    int           first_at;
    int           second_at;
    logic [N-1:0] q_seen;
    logic [N-1:0] r_seen;

    rst      = 1'b0;
    start    = 1'b0;
    data_inN = '0;
    data_inD = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    rst = 1'b0;

    // Directed cases; the model covers whichever build is compiled.
    run_op(8'd200, 8'd7, "d200_7");
    run_op(8'h9C, 8'h07, "dm100_7");
    run_op(8'd100, 8'hF9, "d100_m7");
    run_op(8'd55, 8'd0, "d55_0");
    check("d55_0_q_const", 32'(quotient), 32'hFF);
    check("d55_0_r_const", 32'(remainder), 32'd55);
    run_op(8'd9, 8'd3, "d9_3");
    check("d9_3_q_const", 32'(quotient), 32'd3);
    check("d9_3_dz_const", 32'(div_zero), 32'd0);
    run_op(8'h80, 8'hFF, "ovf");
`ifdef SIGNED_DIV_EN
    check("ovf_q_const", 32'(quotient), 32'h80);
    check("ovf_r_const", 32'(remainder), 32'h00);
`else
    check("ovf_q_const", 32'(quotient), 32'd0);
    check("ovf_r_const", 32'(remainder), 32'd128);
`endif

    // Randomized operands, with extra weight on zero divisors and extreme values.
    for (int i = 0; i < 60; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 9) == 0) a = 8'h80;
      if ($urandom_range(0, 9) == 0) b = 8'hFF;
      run_op(a, b, $sformatf("rnd%0d", i));
    end

    // A second start at E4 with different operands must be ignored.
    model(8'd200, 8'd7, eq, er, ez);
    ndone    = 0;
    first_at = -1;
    q_seen   = '0;
    r_seen   = '0;
    @(negedge clk);
    data_inN = 8'd200;
    data_inD = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (i == 3) begin
        data_inN = 8'd9;
        data_inD = 8'd3;
        start    = 1'b1;
      end
      if (i == 4) start = 1'b0;
      if (done) begin
        ndone++;
        if (first_at < 0) begin
          first_at = i;
          q_seen   = quotient;
          r_seen   = remainder;
        end
      end
    end
    check("e4_ndone", 32'(ndone), 32'd1);
    check("e4_lat", 32'(first_at), 32'(N + 2));
    check("e4_q", 32'(q_seen), 32'(eq));
    check("e4_r", 32'(r_seen), 32'(er));

    // start held high: the restart edge is the one that ends the done cycle, so the
    // second done lands N+2 edges after that, i.e. N+3 edges after the first done.
    first_at  = -1;
    second_at = -1;
    @(negedge clk);
    data_inN = 8'd200;
    data_inD = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        if (first_at < 0) first_at = i;
        else if (second_at < 0) begin
          second_at = i;
          start     = 1'b0;
          check("held_q2", 32'(quotient), 32'(eq));
          check("held_r2", 32'(remainder), 32'(er));
        end
      end
    end
    start = 1'b0;
    check("held_first", 32'(first_at), 32'(N + 2));
    check("held_gap", 32'(second_at - first_at), 32'(N + 3));
    check("held_idle", 32'(busy), 32'd0);

    // Reset at E5 of 200/7 clears everything and suppresses done.
    run_op(8'd9, 8'd0, "pre_rst");
    @(negedge clk);
    data_inN = 8'd200;
    data_inD = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_q", 32'(quotient), 32'd0);
    check("mid_rst_r", 32'(remainder), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_dz", 32'(div_zero), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("mid_rst_quiet", 32'(ndone), 32'd0);
    run_op(8'd200, 8'd7, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
